// File: rtl/artau_pkg.sv
// rtl/artau_pkg.sv - shared types and helpers for the multi-pulse radar target-assessment unit
// Contents:
//   STATE_W       - width of the state encoding
//   artau_state_e - IDLE=00, EMIT=01, LISTEN=10, ASSESS=11
//   cnt_w()       - bit width for a counter spanning 0..n-1
package artau_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_EMIT   = 2'b01,
        ST_LISTEN = 2'b10,
        ST_ASSESS = 2'b11
    } artau_state_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/artau_range_calc.sv
// rtl/artau_range_calc.sv - combinational echo-delay to range conversion and closure-compensated threat test
// Ports:
//   count_i     - listen counter value at the echo sample
//   dist_prev_i - range from the previous pulse
//   jet_speed_i - own closure, distance units per cycle
//   max_safe_i  - threat range threshold
//   dist_o      - saturated count_i * METERS_PER_CYCLE
//   threat_o    - approaching (after closure compensation) and inside the safe range
module artau_range_calc
    import artau_pkg::*;
#(
    parameter int DW               = 32,
    parameter int CW               = 11,
    parameter int PULSE_CYCLES     = 300,
    parameter int METERS_PER_CYCLE = 150
) (
    input  logic [CW-1:0] count_i,
    input  logic [DW-1:0] dist_prev_i,
    input  logic [DW-1:0] jet_speed_i,
    input  logic [DW-1:0] max_safe_i,
    output logic [DW-1:0] dist_o,
    output logic          threat_o
);

    localparam int PW = DW + 32;
    localparam int XW = 2 * DW + 1;

    logic [PW-1:0] prod;
    logic [DW-1:0] interval;
    logic [XW-1:0] closure;

    assign prod   = PW'(count_i) * PW'(METERS_PER_CYCLE);
    assign dist_o = (|prod[PW-1:DW]) ? '1 : prod[DW-1:0];

    // Cycles between the previous echo sample and this one: the full emit
    // window plus listen cycles 0..count_i.
    assign interval = DW'(PULSE_CYCLES) + DW'(count_i) + DW'(1);

    // Wide enough that d_cur + speed*interval can never wrap.
    assign closure  = XW'(dist_o) + XW'(jet_speed_i) * XW'(interval);
    assign threat_o = (closure < XW'(dist_prev_i)) && (dist_o < max_safe_i);

endmodule

// File: rtl/artau_multipulse.sv
// rtl/artau_multipulse.sv - multi-pulse emit/listen/assess radar sequencer with threat detection
// Ports:
//   CLK, RST                - clock, synchronous active-high reset
//   scan_for_target         - request measurement cycles while high
//   radar_echo              - echo detected, sampled only in LISTEN
//   jet_speed               - own closure, distance units per cycle
//   max_safe_distance       - threat range threshold
//   radar_pulse_trigger     - transmitter enable
//   distance_to_target      - latest range
//   threat_detected         - threat flag
//   ARTAU_state             - current state
//   measurement_valid       - one-cycle pulse on ASSESS entry
//   echo_timeout            - one-cycle pulse on listen abort
// Build option: ARTAU_THREAT_STICKY_EN makes threat_detected set-only until RST.
module artau_multipulse
    import artau_pkg::*;
#(
    parameter int DW               = 32,
    parameter int NUM_PULSES       = 2,
    parameter int PULSE_CYCLES     = 300,
    parameter int LISTEN_TIMEOUT   = 2000,
    parameter int STATUS_HOLD      = 3000,
    parameter int METERS_PER_CYCLE = 150
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               scan_for_target,
    input  logic               radar_echo,
    input  logic [DW-1:0]      jet_speed,
    input  logic [DW-1:0]      max_safe_distance,
    output logic               radar_pulse_trigger,
    output logic [DW-1:0]      distance_to_target,
    output logic               threat_detected,
    output logic [STATE_W-1:0] ARTAU_state,
    output logic               measurement_valid,
    output logic               echo_timeout
);

    localparam int EW = cnt_w(PULSE_CYCLES);
    localparam int LW = cnt_w(LISTEN_TIMEOUT);
    localparam int HW = cnt_w(STATUS_HOLD);
    localparam int IW = cnt_w(NUM_PULSES);

    localparam logic [EW-1:0] EMIT_LAST   = EW'(PULSE_CYCLES - 1);
    localparam logic [LW-1:0] LISTEN_LAST = LW'(LISTEN_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(STATUS_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_PULSES - 1);

    artau_state_e  state_q, state_d;
    logic [EW-1:0] emit_cnt_q, emit_cnt_d;
    logic [LW-1:0] listen_cnt_q, listen_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] dist_q, dist_d;
    logic          threat_q, threat_d;
    logic          trig_q, trig_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic [DW-1:0] dist_new;
    logic          threat_new;

    artau_range_calc #(
        .DW               (DW),
        .CW               (LW),
        .PULSE_CYCLES     (PULSE_CYCLES),
        .METERS_PER_CYCLE (METERS_PER_CYCLE)
    ) u_range_calc (
        .count_i     (listen_cnt_q),
        .dist_prev_i (dist_q),
        .jet_speed_i (jet_speed),
        .max_safe_i  (max_safe_distance),
        .dist_o      (dist_new),
        .threat_o    (threat_new)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (scan_for_target) state_d = ST_EMIT;
            ST_EMIT:   if (emit_cnt_q == EMIT_LAST) state_d = ST_LISTEN;
            ST_LISTEN: begin
                // An echo on the final listen cycle still counts.
                if (radar_echo) begin
                    state_d = (idx_q < IDX_LAST) ? ST_EMIT : ST_ASSESS;
                end else if (listen_cnt_q == LISTEN_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSESS: begin
                if (scan_for_target) begin
                    state_d = ST_EMIT;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        emit_cnt_d   = (state_q == ST_EMIT   && state_d == ST_EMIT)   ? emit_cnt_q + 1'b1   : '0;
        listen_cnt_d = (state_q == ST_LISTEN && state_d == ST_LISTEN) ? listen_cnt_q + 1'b1 : '0;
        hold_cnt_d   = (state_q == ST_ASSESS && state_d == ST_ASSESS) ? hold_cnt_q + 1'b1   : '0;

        trig_d    = (state_d == ST_EMIT);
        valid_d   = (state_q == ST_LISTEN && state_d == ST_ASSESS);
        timeout_d = (state_q == ST_LISTEN && state_d == ST_IDLE);

        idx_d = idx_q;
        if (state_q == ST_LISTEN && state_d == ST_EMIT) begin
            idx_d = idx_q + 1'b1;
        end else if (state_q == ST_IDLE || state_q == ST_ASSESS || state_d == ST_IDLE) begin
            idx_d = '0;
        end

        dist_d = dist_q;
        if (state_q == ST_LISTEN && radar_echo) begin
            dist_d = dist_new;
        end else if (state_d == ST_IDLE) begin
            dist_d = '0;
        end

        threat_d = threat_q;
`ifdef ARTAU_THREAT_STICKY_EN
        if (valid_d) begin
            threat_d = threat_q | threat_new;
        end
`else
        if (valid_d) begin
            threat_d = threat_new;
        end else if (state_d == ST_IDLE) begin
            threat_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            emit_cnt_q   <= '0;
            listen_cnt_q <= '0;
            hold_cnt_q   <= '0;
            idx_q        <= '0;
            dist_q       <= '0;
            threat_q     <= 1'b0;
            trig_q       <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            emit_cnt_q   <= emit_cnt_d;
            listen_cnt_q <= listen_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            idx_q        <= idx_d;
            dist_q       <= dist_d;
            threat_q     <= threat_d;
            trig_q       <= trig_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign radar_pulse_trigger = trig_q;
    assign distance_to_target  = dist_q;
    assign threat_detected     = threat_q;
    assign ARTAU_state         = state_q;
    assign measurement_valid   = valid_q;
    assign echo_timeout        = timeout_q;

endmodule

// File: tb/tb_artau_multipulse.sv
// tb/tb_artau_multipulse.sv - directed table-driven bench for artau_multipulse
module tb_artau_multipulse;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        scan_for_target = 1'b0;
    logic        radar_echo = 1'b0;
    logic [31:0] jet_speed = '0;
    logic [31:0] max_safe_distance = '0;
    logic        radar_pulse_trigger;
    logic [31:0] distance_to_target;
    logic        threat_detected;
    logic [1:0]  ARTAU_state;
    logic        measurement_valid;
    logic        echo_timeout;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ARTAU_THREAT_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    artau_multipulse #(
        .DW               (32),
        .NUM_PULSES       (2),
        .PULSE_CYCLES     (3),
        .LISTEN_TIMEOUT   (20),
        .STATUS_HOLD      (30),
        .METERS_PER_CYCLE (150)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .scan_for_target     (scan_for_target),
        .radar_echo          (radar_echo),
        .jet_speed           (jet_speed),
        .max_safe_distance   (max_safe_distance),
        .radar_pulse_trigger (radar_pulse_trigger),
        .distance_to_target  (distance_to_target),
        .threat_detected     (threat_detected),
        .ARTAU_state         (ARTAU_state),
        .measurement_valid   (measurement_valid),
        .echo_timeout        (echo_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          c1;
        int          c2;
        logic [31:0] jet;
        logic [31:0] maxs;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        thr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        scan_for_target = 1'b0;
        radar_echo = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic count_trig(output int n);
        n = 0;
        while (radar_pulse_trigger === 1'b1 && n < 50) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // Called on the first LISTEN negedge (counter value 0).
    task automatic listen_echo(input int c);
        for (int k = 0; k < c; k++) @(negedge CLK);
        radar_echo = 1'b1;
        @(negedge CLK);
        radar_echo = 1'b0;
    endtask

    task automatic run_meas(input vec_t v);
        int n;
        jet_speed = v.jet;
        max_safe_distance = v.maxs;
        scan_for_target = 1'b1;
        @(negedge CLK);
        scan_for_target = 1'b0;
        chk("state_emit1", ARTAU_state, 2'b01);
        count_trig(n);
        chk("trig_len1", n, 3);
        chk("state_listen1", ARTAU_state, 2'b10);
        listen_echo(v.c1);
        chk("dist1", distance_to_target, v.d1);
        chk("state_emit2", ARTAU_state, 2'b01);
        chk("valid_early", measurement_valid, 1'b0);
        count_trig(n);
        chk("trig_len2", n, 3);
        listen_echo(v.c2);
        chk("dist2", distance_to_target, v.d2);
        chk("state_assess", ARTAU_state, 2'b11);
        chk("valid_pulse", measurement_valid, 1'b1);
        chk("threat", threat_detected, v.thr);
    endtask

    initial begin
        int n;
        // c1, c2, jet_speed, max_safe, d1, d2, threat
        vecs[0] = '{10,  8, 32'd10, 32'd2000, 32'd1500, 32'd1200, 1'b1};
        vecs[1] = '{10,  8, 32'd30, 32'd2000, 32'd1500, 32'd1200, 1'b0};
        vecs[2] = '{10, 15, 32'd10, 32'd3000, 32'd1500, 32'd2250, 1'b0};
        vecs[3] = '{ 0,  0, 32'd0,  32'd2000, 32'd0,    32'd0,    1'b0};
        vecs[4] = '{ 5,  4, 32'd0,  32'd500,  32'd750,  32'd600,  1'b0};
        vecs[5] = '{ 5,  4, 32'd18, 32'd601,  32'd750,  32'd600,  1'b1};
        vecs[6] = '{19, 19, 32'd0,  32'd4000, 32'd2850, 32'd2850, 1'b0};

        do_reset();
        chk("rst_state", ARTAU_state, 2'b00);
        chk("rst_trig", radar_pulse_trigger, 1'b0);
        chk("rst_dist", distance_to_target, 0);
        chk("rst_threat", threat_detected, 1'b0);
        chk("rst_valid", measurement_valid, 1'b0);
        chk("rst_timeout", echo_timeout, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_meas(vecs[i]);
            @(negedge CLK);
            chk("valid_once", measurement_valid, 1'b0);
        end

        // Echo on the first pulse, none on the second: timeout after 20 listen cycles.
        do_reset();
        jet_speed = 32'd10;
        max_safe_distance = 32'd2000;
        scan_for_target = 1'b1;
        @(negedge CLK);
        scan_for_target = 1'b0;
        count_trig(n);
        listen_echo(10);
        chk("to_dist1", distance_to_target, 1500);
        count_trig(n);
        n = 0;
        while (ARTAU_state === 2'b10 && n < 40) begin
            n++;
            @(negedge CLK);
        end
        chk("to_listen_len", n, 20);
        chk("to_pulse", echo_timeout, 1'b1);
        chk("to_state", ARTAU_state, 2'b00);
        chk("to_dist", distance_to_target, 0);
        chk("to_threat", threat_detected, 1'b0);
        @(negedge CLK);
        chk("to_pulse_once", echo_timeout, 1'b0);

        // ASSESS held with scan low for STATUS_HOLD cycles, then IDLE.
        do_reset();
        run_meas(vecs[0]);
        n = 0;
        while (ARTAU_state === 2'b11 && n < 60) begin
            n++;
            @(negedge CLK);
        end
        chk("hold_len", n, 30);
        chk("hold_state", ARTAU_state, 2'b00);
        chk("hold_dist", distance_to_target, 0);
        chk("hold_threat", threat_detected, STICKY);

        // Rescan from ASSESS keeps results, then RST during EMIT.
        do_reset();
        run_meas(vecs[0]);
        scan_for_target = 1'b1;
        @(negedge CLK);
        scan_for_target = 1'b0;
        chk("rescan_state", ARTAU_state, 2'b01);
        chk("rescan_trig", radar_pulse_trigger, 1'b1);
        chk("rescan_dist", distance_to_target, 1200);
        chk("rescan_threat", threat_detected, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid_rst_state", ARTAU_state, 2'b00);
        chk("mid_rst_trig", radar_pulse_trigger, 1'b0);
        chk("mid_rst_dist", distance_to_target, 0);
        chk("mid_rst_threat", threat_detected, 1'b0);
        chk("mid_rst_valid", measurement_valid, 1'b0);
        chk("mid_rst_timeout", echo_timeout, 1'b0);
        @(negedge CLK);
        chk("mid_rst_stays_idle", ARTAU_state, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
